// File: rtl/tomasulo_pkg.sv
// Shared definitions for the Tomasulo issue side.
// Contents: ROB and reservation-station sizing, the opcode map,
// the issue-class enum, the ROB entry layout and the opcode decoder.
package tomasulo_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int RS_DEPTH  = 3;
  localparam int FUNC_W    = 4;
  localparam int REG_W     = 4;
  localparam int IDX_W     = $clog2(ROB_DEPTH);
  localparam int CNT_W     = 2;

  typedef enum logic [1:0] {
    CLS_ADD = 2'd0,
    CLS_MUL = 2'd1,
    CLS_BCH = 2'd2,
    CLS_ILL = 2'd3
  } cls_e;

  localparam logic [FUNC_W-1:0] FUNC_ADD0 = 4'b0000;
  localparam logic [FUNC_W-1:0] FUNC_ADD1 = 4'b0001;
  localparam logic [FUNC_W-1:0] FUNC_MUL0 = 4'b0010;
  localparam logic [FUNC_W-1:0] FUNC_MUL1 = 4'b0011;
  localparam logic [FUNC_W-1:0] FUNC_BCH0 = 4'b0100;
  localparam logic [FUNC_W-1:0] FUNC_BCH1 = 4'b0101;

  typedef struct packed {
    logic [FUNC_W-1:0] func;
    logic [REG_W-1:0]  rd;
    logic              done;
  } rob_entry_t;

  function automatic cls_e decode_func(input logic [FUNC_W-1:0] func);
    case (func)
      FUNC_ADD0, FUNC_ADD1: return CLS_ADD;
      FUNC_MUL0, FUNC_MUL1: return CLS_MUL;
      FUNC_BCH0, FUNC_BCH1: return CLS_BCH;
      default:              return CLS_ILL;
    endcase
  endfunction

endpackage

// File: rtl/rs_occ_counter.sv
// Occupancy counter for one reservation-station class.
// Ports:
//   clk1, rst_n  clock and async active-low reset
//   inc          one entry allocated this cycle
//   dec          one entry released this cycle (ignored when empty)
//   flush        clears the count; inc/dec discarded
//   count        current occupancy
//   full         count has reached DEPTH
//   err          sticky: a release arrived while empty (cleared by reset only)
module rs_occ_counter
  import tomasulo_pkg::*;
#(
  parameter int DEPTH = RS_DEPTH
) (
  input  logic             clk1,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             err
);

  logic empty;
  logic dec_ok;

  assign empty  = (count == '0);
  assign dec_ok = dec & ~empty;
  assign full   = (count >= CNT_W'(DEPTH));

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      err   <= 1'b0;
    end else if (flush) begin
      count <= '0;
    end else begin
      count <= count + CNT_W'(inc) - CNT_W'(dec_ok);
      if (dec && empty) err <= 1'b1;
    end
  end

endmodule

// File: rtl/rob_issue_ctrl.sv
// Issue-side controller: owns the ROB head/tail/count, the per-class
// reservation-station occupancy, CDB completion marking and in-order commit.
// Ports:
//   clk1, rst_n                 clock and async active-low reset
//   iss_*                       decoded instruction in, ready/illegal/class/tag out
//   rs_free_add/mul/bch         station entry released
//   cdb_valid, cdb_rob_idx      result broadcast
//   commit_*                    head entry presented to retire; commit_ack accepts
//   flush                       synchronous flush of all bookkeeping (occ_err kept)
//   rob_count, *_count, occ_err status
module rob_issue_ctrl
  import tomasulo_pkg::*;
(
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              iss_valid,
  input  logic [FUNC_W-1:0] iss_func,
  input  logic [REG_W-1:0]  iss_rd,
  output logic              iss_ready,
  output logic              iss_illegal,
  output logic [1:0]        iss_class,
  output logic [IDX_W-1:0]  iss_rob_idx,
  input  logic              rs_free_add,
  input  logic              rs_free_mul,
  input  logic              rs_free_bch,
  input  logic              cdb_valid,
  input  logic [IDX_W-1:0]  cdb_rob_idx,
  output logic              commit_valid,
  output logic [IDX_W-1:0]  commit_rob_idx,
  output logic [FUNC_W-1:0] commit_func,
  output logic [REG_W-1:0]  commit_rd,
  input  logic              commit_ack,
  input  logic              flush,
  output logic [IDX_W:0]    rob_count,
  output logic [CNT_W-1:0]  add_count,
  output logic [CNT_W-1:0]  mul_count,
  output logic [CNT_W-1:0]  bch_count,
  output logic              occ_err
);

  rob_entry_t       rob [ROB_DEPTH];
  logic [IDX_W-1:0] head;
  logic [IDX_W-1:0] tail;
  logic [IDX_W:0]   count_q;
  cls_e             cls;
  logic             cls_full;
  logic             add_full, mul_full, bch_full;
  logic             add_err, mul_err, bch_err;
  logic             issue_fire;
  logic             commit_fire;
  logic [IDX_W-1:0] cdb_offset;
  logic             cdb_hit;
  rob_entry_t       head_entry;

  assign cls = decode_func(iss_func);

  always_comb begin
    cls_full = 1'b1;
    case (cls)
      CLS_ADD: cls_full = add_full;
      CLS_MUL: cls_full = mul_full;
      CLS_BCH: cls_full = bch_full;
      default: cls_full = 1'b1;
    endcase
  end

  // Readiness looks only at registered state, so a same-cycle commit or
  // free never opens a slot for the instruction presented alongside it.
  assign iss_ready   = (cls != CLS_ILL) & (count_q < (IDX_W+1)'(ROB_DEPTH)) & ~cls_full;
  assign iss_illegal = iss_valid & (cls == CLS_ILL);
  assign iss_class   = cls;
  assign iss_rob_idx = tail;

  assign head_entry     = rob[head];
  assign commit_valid   = (count_q != '0) & head_entry.done;
  assign commit_rob_idx = head;
  assign commit_func    = head_entry.func;
  assign commit_rd      = head_entry.rd;
  assign rob_count      = count_q;

  assign issue_fire  = iss_valid & iss_ready & ~flush;
  assign commit_fire = commit_valid & commit_ack & ~flush;

  // A tag is live when its distance from head (mod depth) is below the count.
  assign cdb_offset = cdb_rob_idx - head;
  assign cdb_hit    = cdb_valid & ~flush & ({1'b0, cdb_offset} < count_q);

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) rob[i] <= '0;
    end else if (flush) begin
      head    <= '0;
      tail    <= '0;
      count_q <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) rob[i].done <= 1'b0;
    end else begin
      if (cdb_hit) rob[cdb_rob_idx].done <= 1'b1;
      if (commit_fire) begin
        rob[head].done <= 1'b0;
        head           <= head + 1'b1;
      end
      if (issue_fire) begin
        rob[tail] <= '{func: iss_func, rd: iss_rd, done: 1'b0};
        tail      <= tail + 1'b1;
      end
      case ({issue_fire, commit_fire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  rs_occ_counter u_add_occ (
    .clk1  (clk1),
    .rst_n (rst_n),
    .inc   (issue_fire & (cls == CLS_ADD)),
    .dec   (rs_free_add),
    .flush (flush),
    .count (add_count),
    .full  (add_full),
    .err   (add_err)
  );

  rs_occ_counter u_mul_occ (
    .clk1  (clk1),
    .rst_n (rst_n),
    .inc   (issue_fire & (cls == CLS_MUL)),
    .dec   (rs_free_mul),
    .flush (flush),
    .count (mul_count),
    .full  (mul_full),
    .err   (mul_err)
  );

  rs_occ_counter u_bch_occ (
    .clk1  (clk1),
    .rst_n (rst_n),
    .inc   (issue_fire & (cls == CLS_BCH)),
    .dec   (rs_free_bch),
    .flush (flush),
    .count (bch_count),
    .full  (bch_full),
    .err   (bch_err)
  );

  assign occ_err = add_err | mul_err | bch_err;

endmodule

// File: doc/rob_issue_ctrl.md
# rob_issue_ctrl

Issue-side controller for the Tomasulo core: it owns the 8-entry reorder buffer (ROB) allocation pointers and the add/mul/branch reservation-station occupancy counters. It decides each cycle whether the presented decoded instruction may issue, hands out the ROB tag, and tracks completion from the CDB. It presents in-order commits to the retire logic. It sits between decode and the reservation-station append logic and replaces ad-hoc stall decisions with one registered bookkeeping point.

## Interface
- ROB_DEPTH, 8: ROB entries; power of two; index width IDX_W = log2(ROB_DEPTH).
- RS_DEPTH, 3: entries per reservation-station class.
- FUNC_W, 4: opcode width.
- REG_W, 4: architectural register index width.

Ports:
- clk1  in  1  the single clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- iss_valid  in  1  decoded instruction presented.
- iss_func  in  FUNC_W  opcode.
- iss_rd  in  REG_W  destination register.
- iss_ready  out  1  issue is accepted this cycle; issue fires on iss_valid & iss_ready.
- iss_illegal  out  1  iss_valid with an undecodable func.
- iss_class  out  2  decoded class: 0 add, 1 mul, 2 branch, 3 illegal.
- iss_rob_idx  out  IDX_W  ROB tag allocated on fire (current tail).
- rs_free_add, rs_free_mul, rs_free_bch  in  1 each  one station entry released this cycle.
- cdb_valid  in  1  a result is broadcast this cycle.
- cdb_rob_idx  in  IDX_W  tag of the broadcast result.
- commit_valid  out  1  head entry done and ROB non-empty.
- commit_rob_idx  out  IDX_W  head pointer.
- commit_func  out  FUNC_W  head opcode.
- commit_rd  out  REG_W  head destination.
- commit_ack  in  1  retire accepts; commit fires on commit_valid & commit_ack.
- flush  in  1  synchronous pipeline flush.
- rob_count  out  IDX_W+1  occupied ROB entries.
- add_count, mul_count, bch_count  out  2 each  station occupancy.
- occ_err  out  1  sticky: rs_free seen on an empty class.

## Operation
- Decode: func 0000/0001 add; 0010/0011 mul; 0100/0101 branch; all others illegal.
- iss_ready = legal class & rob_count < ROB_DEPTH & class count < RS_DEPTH. Illegal func gives iss_ready 0 and iss_illegal 1. Upstream must drop the instruction.
- Issue fire:
  - writes {func, rd, done=0} at tail.
  - tail increments modulo ROB_DEPTH; rob_count increments.
  - the class counter increments.
- rs_free_x decrements its counter. On count 0 the free is ignored and occ_err is set.
- cdb_valid sets done[cdb_rob_idx] only if that entry is currently allocated. Otherwise it is ignored.
- Commit fire: head increments modulo ROB_DEPTH; rob_count decrements; done[head] is cleared.
- Simultaneous events:
  - Issue plus commit in the same cycle leaves rob_count unchanged.
  - Issue plus rs_free of the same class leaves that count unchanged.
  - There is no bypass: a full ROB or full class stays not-ready even if a commit or free occurs in the same cycle.
- flush has highest priority. It zeroes head, tail, rob_count, all class counts and all done bits. Any issue, commit, free or CDB event in that cycle is discarded. occ_err is kept.
- Reset clears all state. Registered outputs are 0 and occ_err is 0. Combinational outputs follow empty state: commit_valid 0, and iss_ready = 1 for a legal func.

## Timing
- iss_ready, iss_illegal, iss_class and iss_rob_idx are combinational from iss_func and registered state. There is no path from commit_ack, rs_free or cdb to iss_ready.
- commit_valid, commit_rob_idx, commit_func and commit_rd are combinational from registered state only.
- CDB at edge N: commit_valid can assert from N+1.
- Issue at N: the new entry is counted in rob_count from N+1. Earliest commit is N+2, which needs the CDB at N+1.
- Reset is asynchronous assert. Deassertion is synchronized outside this block.

## Structure
- Shared tomasulo_pkg: class enum (CLS_ADD, CLS_MUL, CLS_BCH, CLS_ILL), func opcode constants, ROB_DEPTH, RS_DEPTH, ROB entry struct {func, rd, done}.
- Sub-module rs_occ_counter: up/down counter with inc, dec, flush, full, empty and an underflow-error flag; instantiated three times.

## Test plan
- Reset then issue func 0000, rd 5: iss_rob_idx 0, next cycle rob_count 1 and add_count 1. CDB tag 0 then commit_valid with commit_rd 5. Ack: rob_count 0.
- Issue 3 mul with no free: 4th mul gets iss_ready 0 while an add is still ready. rs_free_mul for one cycle: mul ready next cycle.
- Issue 8 instructions across classes with frees: 9th stalls. Commit plus issue in the full cycle: issue refused. Next cycle the issue fires with tag 0 (wrap).
- CDB tags 2, 1, 0 out of order: commits occur in order 0, 1, 2, each one cycle after its done bit. CDB to an unallocated tag 6 has no effect.
- Four entries in flight, assert flush together with issue and commit_ack: next cycle all counts are 0, tail 0, and no entry is committed.
- func 1111: iss_illegal 1, iss_ready 0, no state change. rs_free_bch on empty: occ_err 1, survives flush, clears only on rst_n.
